// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM and grant encodings,
// plus the fixed values driven for instruction fetches.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_IF  = 2'd1,
        ST_BUSY_MEM = 2'd2,
        ST_RESP     = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    // Fetches are always word reads
    localparam logic [2:0]  DEFAULT_FUNCT3  = 3'b010;
    localparam logic [31:0] DEFAULT_32_ZERO = '0;

endpackage

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// Bus wait counter: cleared outside a transfer, counts un-acked busy
// cycles and saturates at TIMEOUT_CYCLES-1, flagging done there.
module arb_timeout_cnt
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rest,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Saturating wait counter; holds at the terminal value instead of wrapping
    always_ff @(posedge clk) begin
        if (!rest) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == LAST_CNT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the IF-stage fetch port and the MEM-stage load/store port onto
// one shared memory bus, alternating grants on ties and aborting stalled
// transfers after TIMEOUT_CYCLES busy cycles.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rest,
    // instruction fetch port
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    // MEM stage port
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [2:0]  mem_funct3_i,
    output logic        mem_rvalid_o,
    output logic [31:0] mem_rdata_o,
    // shared bus
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [2:0]  bus_funct3_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    // pipeline control
    output logic        stall_if_o,
    output logic        stall_mem_o,
    output logic        err_o
);

    arb_state_e  state;
    grant_e      cur_grant;
    grant_e      last_grant;
    logic        busy;
    logic        cnt_done;
    logic        pick_mem;
    logic [31:0] resp_data;

    assign busy = (state == ST_BUSY_IF) || (state == ST_BUSY_MEM);

    arb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .rest   (rest),
        .clear  (!busy),
        .enable (busy && !bus_ack_i),
        .done   (cnt_done)
    );

    // Grant selection and response data for the current cycle
    always_comb begin
        pick_mem  = mem_req_i && (!if_req_i || (last_grant == GRANT_IF));
        resp_data = bus_ack_i ? bus_rdata_i : DEFAULT_32_ZERO;
    end

    // Arbiter FSM with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (!rest) begin
            state        <= ST_IDLE;
            cur_grant    <= GRANT_IF;
            last_grant   <= GRANT_IF;
            bus_req_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= '0;
            bus_wdata_o  <= '0;
            bus_funct3_o <= '0;
            if_rvalid_o  <= 1'b0;
            if_rdata_o   <= '0;
            mem_rvalid_o <= 1'b0;
            mem_rdata_o  <= '0;
            err_o        <= 1'b0;
        end else begin
            if_rvalid_o  <= 1'b0;
            mem_rvalid_o <= 1'b0;
            err_o        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_mem) begin
                        state        <= ST_BUSY_MEM;
                        cur_grant    <= GRANT_MEM;
                        bus_req_o    <= 1'b1;
                        bus_we_o     <= mem_we_i;
                        bus_addr_o   <= mem_addr_i;
                        bus_wdata_o  <= mem_wdata_i;
                        bus_funct3_o <= mem_funct3_i;
                    end else if (if_req_i) begin
                        state        <= ST_BUSY_IF;
                        cur_grant    <= GRANT_IF;
                        bus_req_o    <= 1'b1;
                        bus_we_o     <= 1'b0;
                        bus_addr_o   <= if_addr_i;
                        bus_wdata_o  <= DEFAULT_32_ZERO;
                        bus_funct3_o <= DEFAULT_FUNCT3;
                    end
                end
                ST_BUSY_IF, ST_BUSY_MEM: begin
                    // ack wins over a coincident timeout
                    if (bus_ack_i || cnt_done) begin
                        state     <= ST_RESP;
                        bus_req_o <= 1'b0;
                        err_o     <= !bus_ack_i;
                        if (cur_grant == GRANT_IF) begin
                            if_rvalid_o <= 1'b1;
                            if_rdata_o  <= resp_data;
                        end else begin
                            mem_rvalid_o <= 1'b1;
                            mem_rdata_o  <= resp_data;
                        end
                    end
                end
                ST_RESP: begin
                    last_grant <= cur_grant;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stall_if_o  = if_req_i && !if_rvalid_o;
    assign stall_mem_o = mem_req_i && !mem_rvalid_o;

endmodule
